// File: rtl/jtpopeye_layer_mix_pkg.sv
// jtpopeye_layer_mix_pkg: shared layer id width, fade level constants and RGB packing helpers
package jtpopeye_layer_mix_pkg;
    localparam int LW = 2;
    localparam int FADE_W = 4;
    localparam logic [FADE_W-1:0] FADE_MAX = 4'd8;
    // palette words are packed {r,g,b} with blue in the LSBs
    function automatic int red_lsb(input int gw, input int bw);
        return gw + bw;
    endfunction
    function automatic int green_lsb(input int bw);
        return bw;
    endfunction
endpackage

// File: rtl/jtpopeye_layer_mix_if.sv
// jtpopeye_layer_mix_if: pixel, palette-programming, priority, fade and RGB/sync signals of the mixer
// master drives layers/programming and receives RGB; slave is the mixer.
interface jtpopeye_layer_mix_if
    import jtpopeye_layer_mix_pkg::*;
#(
    parameter int LAYERS = 3,
    parameter int CW     = 5,
    parameter int RW     = 3,
    parameter int GW     = 3,
    parameter int BW     = 2
);
    localparam int DW = RW + GW + BW;
    localparam int AW = LW + CW;
    logic                 cen;
    logic [LAYERS*CW-1:0] lyr_col;
    logic [LAYERS-1:0]    lyr_v;
    logic                 HB_n;
    logic                 VB_n;
    logic [AW-1:0]        prog_addr;
    logic [DW-1:0]        prog_din;
    logic                 prog_we;
    logic [LAYERS*LW-1:0] prio_din;
    logic                 prio_we;
    logic                 fade_start;
    logic                 fade_dir;
    logic [RW-1:0]        red;
    logic [GW-1:0]        green;
    logic [BW-1:0]        blue;
    logic                 HB_out_n;
    logic                 VB_out_n;
    logic                 fade_busy;
    modport master (
        output cen, lyr_col, lyr_v, HB_n, VB_n, prog_addr, prog_din, prog_we,
               prio_din, prio_we, fade_start, fade_dir,
        input  red, green, blue, HB_out_n, VB_out_n, fade_busy
    );
    modport slave (
        input  cen, lyr_col, lyr_v, HB_n, VB_n, prog_addr, prog_din, prog_we,
               prio_din, prio_we, fade_start, fade_dir,
        output red, green, blue, HB_out_n, VB_out_n, fade_busy
    );
endinterface

// File: rtl/jtpopeye_prio_sel.sv
// jtpopeye_prio_sel: S1 winner select with pending/active (frame double-buffered) priority registers
// In: clk, rst, cen, lyr_col, lyr_v, prio_din, prio_we, vb_fall. Out: registered winner id and index.
module jtpopeye_prio_sel
    import jtpopeye_layer_mix_pkg::*;
#(
    parameter int LAYERS = 3,
    parameter int CW     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [LAYERS*CW-1:0] lyr_col,
    input  logic [LAYERS-1:0]    lyr_v,
    input  logic [LAYERS*LW-1:0] prio_din,
    input  logic                 prio_we,
    input  logic                 vb_fall,
    output logic [LW-1:0]        win_id_q,
    output logic [CW-1:0]        win_idx_q
);
    function automatic logic [LAYERS*LW-1:0] ident();
        logic [LAYERS*LW-1:0] v;
        for (int r = 0; r < LAYERS; r++) v[r*LW +: LW] = LW'(r);
        return v;
    endfunction
    logic [LAYERS*LW-1:0] pend_q, pend_d, act_q, act_d;
    logic [LW-1:0]        win_id, win_id_d;
    logic [CW-1:0]        win_idx_d;
    // zero-padded to all 2^LW ids so out-of-range ids read as transparent, index 0
    logic [2**LW-1:0]     v_ext;
    logic [2**LW*CW-1:0]  col_ext;
    always_comb begin
        v_ext = '0;
        v_ext[LAYERS-1:0] = lyr_v;
        col_ext = '0;
        col_ext[LAYERS*CW-1:0] = lyr_col;
        // scan from the lowest rank upward so the first opaque rank overrides the backdrop
        win_id = act_q[(LAYERS-1)*LW +: LW];
        for (int r = LAYERS-1; r >= 0; r--)
            if (v_ext[act_q[r*LW +: LW]]) win_id = act_q[r*LW +: LW];
        win_id_d = cen ? win_id : win_id_q;
        win_idx_d = cen ? col_ext[win_id*CW +: CW] : win_idx_q;
        pend_d = prio_we ? prio_din : pend_q;
        act_d = vb_fall ? pend_q : act_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= ident();
            act_q     <= ident();
            win_id_q  <= '0;
            win_idx_q <= '0;
        end else begin
            pend_q    <= pend_d;
            act_q     <= act_d;
            win_id_q  <= win_id_d;
            win_idx_q <= win_idx_d;
        end
    end
endmodule

// File: rtl/jtpopeye_layer_mix.sv
// jtpopeye_layer_mix: N-layer priority mixer with shared palette, blanking and optional frame fade
// Ports: clk, rst and a jtpopeye_layer_mix_if.slave bus (layers, sync, palette/priority programming, RGB out).
// Pipeline: S1 winner select, S2 palette read, S3 blank/fade and output; 3 cen cycles.
// Build option: define COLMIX_FADE_EN to enable the per-frame fade FSM.
module jtpopeye_layer_mix
    import jtpopeye_layer_mix_pkg::*;
#(
    parameter int    LAYERS  = 3,
    parameter int    CW      = 5,
    parameter int    RW      = 3,
    parameter int    GW      = 3,
    parameter int    BW      = 2,
    parameter string SIMFILE = ""
) (
    input logic               clk,
    input logic               rst,
    jtpopeye_layer_mix_if.slave bus
);
    localparam int DW = RW + GW + BW;
    localparam int AW = LW + CW;
    localparam bit unused_simfile = (SIMFILE == "");
    logic               vb_last_q, vb_last_d, vb_fall;
    logic [LW-1:0]      win_id_q;
    logic [CW-1:0]      win_idx_q;
    logic [1:0]         s1_syn_q, s1_syn_d, s2_syn_q, s2_syn_d, s3_syn_q, s3_syn_d;
    logic [DW-1:0]      pal_mem [0:2**AW-1];
    logic [DW-1:0]      rd_q;
    logic [DW-1:0]      rgb_q, rgb_d;
    logic [FADE_W-1:0]  level;
    logic [RW+FADE_W-1:0] r_full;
    logic [GW+FADE_W-1:0] g_full;
    logic [BW+FADE_W-1:0] b_full;
    assign vb_fall = bus.cen & vb_last_q & ~bus.VB_n;
    jtpopeye_prio_sel #(.LAYERS(LAYERS), .CW(CW)) u_sel (
        .clk      (clk),
        .rst      (rst),
        .cen      (bus.cen),
        .lyr_col  (bus.lyr_col),
        .lyr_v    (bus.lyr_v),
        .prio_din (bus.prio_din),
        .prio_we  (bus.prio_we),
        .vb_fall  (vb_fall),
        .win_id_q (win_id_q),
        .win_idx_q(win_idx_q)
    );
    // write port is free-running; the read port advances with the pixel pipeline and
    // sees the pre-write word on a same-address collision
    always_ff @(posedge clk) begin
        if (bus.prog_we) pal_mem[bus.prog_addr] <= bus.prog_din;
        if (bus.cen) rd_q <= pal_mem[{win_id_q, win_idx_q}];
    end
`ifdef COLMIX_FADE_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] STEP = 1'b1;
    logic [0:0]        st_q, st_d;
    logic              dir_q, dir_d;
    logic [FADE_W-1:0] lvl_q, lvl_d, tgt;
    assign tgt = dir_q ? FADE_MAX : '0;
    always_comb begin
        st_d  = st_q;
        dir_d = dir_q;
        lvl_d = lvl_q;
        if (st_q == IDLE) begin
            st_d  = bus.fade_start ? STEP : IDLE;
            dir_d = bus.fade_start ? bus.fade_dir : dir_q;
        end else if (vb_fall) begin
            lvl_d = lvl_q == tgt ? lvl_q : dir_q ? lvl_q + 4'd1 : lvl_q - 4'd1;
            st_d  = lvl_d == tgt ? IDLE : STEP;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            dir_q <= 1'b0;
            lvl_q <= FADE_MAX;
        end else begin
            st_q  <= st_d;
            dir_q <= dir_d;
            lvl_q <= lvl_d;
        end
    end
    assign level = lvl_q;
    assign bus.fade_busy = st_q == STEP;
`else
    logic unused_fade;
    assign unused_fade = ^{bus.fade_start, bus.fade_dir};
    assign level = FADE_MAX;
    assign bus.fade_busy = 1'b0;
`endif
    always_comb begin
        vb_last_d = bus.cen ? bus.VB_n : vb_last_q;
        s1_syn_d = bus.cen ? {bus.HB_n, bus.VB_n} : s1_syn_q;
        s2_syn_d = bus.cen ? s1_syn_q : s2_syn_q;
        s3_syn_d = bus.cen ? s2_syn_q : s3_syn_q;
        r_full = (RW+FADE_W)'(rd_q[red_lsb(GW, BW) +: RW]) * (RW+FADE_W)'(level);
        g_full = (GW+FADE_W)'(rd_q[green_lsb(BW) +: GW]) * (GW+FADE_W)'(level);
        b_full = (BW+FADE_W)'(rd_q[0 +: BW]) * (BW+FADE_W)'(level);
        // blank is reconstructed from the delayed syncs rather than carried separately
        rgb_d = !bus.cen ? rgb_q :
                !(&s2_syn_q) ? '0 : {r_full[3 +: RW], g_full[3 +: GW], b_full[3 +: BW]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vb_last_q <= 1'b0;
            s1_syn_q  <= '0;
            s2_syn_q  <= '0;
            s3_syn_q  <= '0;
            rgb_q     <= '0;
        end else begin
            vb_last_q <= vb_last_d;
            s1_syn_q  <= s1_syn_d;
            s2_syn_q  <= s2_syn_d;
            s3_syn_q  <= s3_syn_d;
            rgb_q     <= rgb_d;
        end
    end
    assign bus.red      = rgb_q[red_lsb(GW, BW) +: RW];
    assign bus.green    = rgb_q[green_lsb(BW) +: GW];
    assign bus.blue     = rgb_q[0 +: BW];
    assign bus.HB_out_n = s3_syn_q[1];
    assign bus.VB_out_n = s3_syn_q[0];
endmodule
